// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier.
//   mult_state_t : controller states (IDLE, RUN, DONE)
//   booth_op_t   : accumulator operation chosen for one step
//   boothDecode  : maps mode and the low multiplier bits to an accumulator operation
package mult_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;

  typedef enum logic [1:0] {OP_NONE, OP_ADD, OP_SUB} booth_op_t;

  // Unsigned mode adds M whenever the retiring bit is 1. Signed mode uses radix-2
  // Booth recoding on the pair {Q[0], Qm1}: 01 adds M, 10 subtracts M.
  function automatic booth_op_t boothDecode(input logic signedMode,
                                            input logic q0,
                                            input logic qm1);
    booth_op_t op;
    op = OP_NONE;
    if (!signedMode) begin
      if (q0) op = OP_ADD;
    end else begin
      case ({q0, qm1})
        2'b01:   op = OP_ADD;
        2'b10:   op = OP_SUB;
        default: op = OP_NONE;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/mult_datapath.sv
// Register/arithmetic half of the sequential multiplier.
// Holds M, A, Q, the carry/sign bit C, the Booth history bit Qm1 and the latched mode.
// Ports:
//   clock_i         rising-edge clock
//   reset_i         synchronous active-high reset, clears every register
//   load_i          latch operands and mode, clear A/C/Qm1
//   step_i          perform one combined add/subtract + right shift
//   signed_mode_i   mode to latch on load (0 unsigned, 1 signed Booth)
//   multiplicand_i  operand M
//   multiplier_i    operand Q
//   product_o       {A,Q}
module mult_datapath
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clock_i,
  input  logic           reset_i,
  input  logic           load_i,
  input  logic           step_i,
  input  logic           signed_mode_i,
  input  logic [N-1:0]   multiplicand_i,
  input  logic [N-1:0]   multiplier_i,
  output logic [2*N-1:0] product_o
);

  logic [N-1:0] m_q, a_q, q_q;
  logic         c_q, qm1_q, signedMode_q;

  logic [N-1:0] a_d, q_d;
  logic         c_d, qm1_d;
  logic [N:0]   aExt, mExt, sum;
  booth_op_t    op;

  // One step of the algorithm. The accumulator is widened to N+1 bits (zero
  // extension when unsigned, sign extension when signed) so neither mode can
  // overflow, even for M = -2^(N-1). After the add the whole {C,A,Q} chain moves
  // right by one; in unsigned mode a 0 enters at the top, in signed mode the sign
  // (sum[N]) is kept. Either way the new A is sum[N:1], so only C differs.
  always_comb begin
    op    = boothDecode(signedMode_q, q_q[0], qm1_q);
    aExt  = signedMode_q ? {a_q[N-1], a_q} : {1'b0, a_q};
    mExt  = signedMode_q ? {m_q[N-1], m_q} : {1'b0, m_q};
    sum   = aExt;
    case (op)
      OP_ADD:  sum = aExt + mExt;
      OP_SUB:  sum = aExt - mExt;
      default: sum = aExt;
    endcase
    c_d   = signedMode_q ? sum[N] : 1'b0;
    a_d   = sum[N:1];
    q_d   = {sum[0], q_q[N-1:1]};
    qm1_d = q_q[0];
  end

  // Register bank: reset clears everything, load starts a fresh operation,
  // step retires one multiplier bit. Outside load/step the registers hold,
  // which keeps the product stable after completion.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      m_q          <= '0;
      a_q          <= '0;
      q_q          <= '0;
      c_q          <= 1'b0;
      qm1_q        <= 1'b0;
      signedMode_q <= 1'b0;
    end else if (load_i) begin
      m_q          <= multiplicand_i;
      a_q          <= '0;
      q_q          <= multiplier_i;
      c_q          <= 1'b0;
      qm1_q        <= 1'b0;
      signedMode_q <= signed_mode_i;
    end else if (step_i) begin
      a_q          <= a_d;
      q_q          <= q_d;
      c_q          <= c_d;
      qm1_q        <= qm1_d;
    end
  end

  assign product_o = {a_q, q_q};

  logic unusedC;
  assign unusedC = c_q;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential N x N multiplier, one multiplier bit per clock, unsigned shift-add
// or signed radix-2 Booth chosen per operation.
// Ports:
//   clock         rising-edge clock
//   reset         synchronous active-high reset
//   start         request an operation (honoured in IDLE or DONE only)
//   signed_mode   0 unsigned, 1 signed; latched with the operands
//   multiplicand  operand M
//   multiplier    operand Q
//   busy          high while an operation is stepping
//   done          one-cycle completion pulse
//   product       2N-bit result {A,Q}, valid from done until the next accepted start
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           signed_mode,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);

  mult_state_t   state_q;
  logic [CW-1:0] count_q;
  logic          busy_q, done_q;
  logic          accept, step;

  // A start is only taken when the unit is not stepping; DONE accepts directly
  // so back-to-back operations skip IDLE.
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));
  assign step   = (state_q == RUN);

  // Controller: counts N steps, then raises done for one cycle. busy and done
  // are registered alongside the state so they track it exactly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            count_q <= CW'(N);
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          count_q <= count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q <= RUN;
            count_q <= CW'(N);
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  mult_datapath #(.N(N)) datapath (
    .clock_i        (clock),
    .reset_i        (reset),
    .load_i         (accept),
    .step_i         (step),
    .signed_mode_i  (signed_mode),
    .multiplicand_i (multiplicand),
    .multiplier_i   (multiplier),
    .product_o      (product)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised checks for seq_multiplier at N=4 and N=8.
module tb_seq_multiplier;

  logic        clock = 1'b0;
  logic        reset;

  logic        start4, mode4, busy4, done4;
  logic [3:0]  mcand4, mplier4;
  logic [7:0]  product4;

  logic        start8, mode8, busy8, done8;
  logic [7:0]  mcand8, mplier8;
  logic [15:0] product8;

  int checkCount = 0;
  int errorCount = 0;

  seq_multiplier #(.N(4)) dut4 (
    .clock(clock), .reset(reset), .start(start4), .signed_mode(mode4),
    .multiplicand(mcand4), .multiplier(mplier4),
    .busy(busy4), .done(done4), .product(product4)
  );

  seq_multiplier #(.N(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(mode8),
    .multiplicand(mcand8), .multiplier(mplier8),
    .busy(busy8), .done(done8), .product(product8)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    bit          wide;
    bit          mode;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] expected;
  } vector_t;

  vector_t vectors[14];

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference: plain integer multiplication at the operand width.
  function automatic logic [15:0] refProduct(input bit wide, input bit mode,
                                             input logic [7:0] a, input logic [7:0] b);
    logic signed [15:0] sa, sb, p;
    if (wide) begin
      sa = mode ? {{8{a[7]}}, a} : {8'h00, a};
      sb = mode ? {{8{b[7]}}, b} : {8'h00, b};
      p  = sa * sb;
      return p;
    end
    sa = mode ? {{12{a[3]}}, a[3:0]} : {12'h000, a[3:0]};
    sb = mode ? {{12{b[3]}}, b[3:0]} : {12'h000, b[3:0]};
    p  = sa * sb;
    return {8'h00, p[7:0]};
  endfunction

  task automatic driveInputs(input bit wide, input bit s, input bit mode,
                             input logic [7:0] a, input logic [7:0] b);
    if (wide) begin
      start8 = s; mode8 = mode; mcand8 = a; mplier8 = b;
    end else begin
      start4 = s; mode4 = mode; mcand4 = a[3:0]; mplier4 = b[3:0];
    end
  endtask

  function automatic logic getBusy(input bit wide);
    return wide ? busy8 : busy4;
  endfunction

  function automatic logic getDone(input bit wide);
    return wide ? done8 : done4;
  endfunction

  function automatic logic [15:0] getProduct(input bit wide);
    return wide ? product8 : {8'h00, product4};
  endfunction

  // Waits (bounded) for done, starting at the negedge after the accept edge.
  // Returns edges counted and whether busy stayed high while waiting.
  task automatic waitDone(input bit wide, output int cycles, output bit busyOk);
    cycles = 0;
    busyOk = 1'b1;
    while (getDone(wide) !== 1'b1 && cycles < 40) begin
      if (getBusy(wide) !== 1'b1) busyOk = 1'b0;
      @(negedge clock);
      cycles++;
    end
  endtask

  // One complete operation with latency, busy, product and pulse-width checks.
  task automatic applyStimulus(input string name, input bit wide, input bit mode,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic [15:0] expected);
    int          cycles;
    bit          busyOk;
    logic [15:0] held;
    @(negedge clock);
    driveInputs(wide, 1'b1, mode, a, b);
    @(negedge clock);
    driveInputs(wide, 1'b0, ~mode, ~a, ~b);
    waitDone(wide, cycles, busyOk);
    checkOutput({name, " latency"}, 16'(cycles), wide ? 16'd8 : 16'd4);
    checkOutput({name, " busyDuringRun"}, {15'd0, busyOk}, 16'd1);
    checkOutput({name, " product"}, getProduct(wide), expected);
    checkOutput({name, " busyAtDone"}, {15'd0, getBusy(wide)}, 16'd0);
    held = getProduct(wide);
    @(negedge clock);
    checkOutput({name, " donePulse"}, {15'd0, getDone(wide)}, 16'd0);
    checkOutput({name, " productHeld"}, getProduct(wide), held);
  endtask

  initial begin
    int          cycles;
    bit          busyOk;
    bit          doneSeen;
    logic [7:0]  ra, rb;

    vectors[0]  = '{"u4 DxB",   1'b0, 1'b0, 8'h0D, 8'h0B, 16'h008F};
    vectors[1]  = '{"s4 Dx5",   1'b0, 1'b1, 8'h0D, 8'h05, 16'h00F1};
    vectors[2]  = '{"s4 8x8",   1'b0, 1'b1, 8'h08, 8'h08, 16'h0040};
    vectors[3]  = '{"u4 FxF",   1'b0, 1'b0, 8'h0F, 8'h0F, 16'h00E1};
    vectors[4]  = '{"s4 7x8",   1'b0, 1'b1, 8'h07, 8'h08, 16'h00C8};
    vectors[5]  = '{"s4 FxF",   1'b0, 1'b1, 8'h0F, 8'h0F, 16'h0001};
    vectors[6]  = '{"u4 0x7",   1'b0, 1'b0, 8'h00, 8'h07, 16'h0000};
    vectors[7]  = '{"s4 3xC",   1'b0, 1'b1, 8'h03, 8'h0C, 16'h00F4};
    vectors[8]  = '{"u8 E5x47", 1'b1, 1'b0, 8'hE5, 8'h47, 16'h3F83};
    vectors[9]  = '{"s8 E5x47", 1'b1, 1'b1, 8'hE5, 8'h47, 16'hF883};
    vectors[10] = '{"s8 80x80", 1'b1, 1'b1, 8'h80, 8'h80, 16'h4000};
    vectors[11] = '{"s8 80x7F", 1'b1, 1'b1, 8'h80, 8'h7F, 16'hC080};
    vectors[12] = '{"u8 FFxFF", 1'b1, 1'b0, 8'hFF, 8'hFF, 16'hFE01};
    vectors[13] = '{"s8 00x9C", 1'b1, 1'b1, 8'h00, 8'h9C, 16'h0000};

    reset = 1'b1;
    driveInputs(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    driveInputs(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clock);
    checkOutput("reset busy4",    {15'd0, busy4}, 16'd0);
    checkOutput("reset done4",    {15'd0, done4}, 16'd0);
    checkOutput("reset product4", {8'h00, product4}, 16'h0000);
    checkOutput("reset busy8",    {15'd0, busy8}, 16'd0);
    checkOutput("reset done8",    {15'd0, done8}, 16'd0);
    checkOutput("reset product8", product8, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 14; i++)
      applyStimulus(vectors[i].name, vectors[i].wide, vectors[i].mode,
                    vectors[i].a, vectors[i].b, vectors[i].expected);

    // start held through RUN with operands changing; the DONE cycle re-accepts
    @(negedge clock);
    driveInputs(1'b1, 1'b1, 1'b0, 8'hE5, 8'h47);
    @(negedge clock);
    driveInputs(1'b1, 1'b1, 1'b0, 8'hFF, 8'h02);
    waitDone(1'b1, cycles, busyOk);
    checkOutput("b2b first latency", 16'(cycles), 16'd8);
    checkOutput("b2b first busy", {15'd0, busyOk}, 16'd1);
    checkOutput("b2b first product", product8, 16'h3F83);
    @(negedge clock);
    driveInputs(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    checkOutput("b2b reaccept busy", {15'd0, busy8}, 16'd1);
    checkOutput("b2b reaccept done", {15'd0, done8}, 16'd0);
    waitDone(1'b1, cycles, busyOk);
    checkOutput("b2b second latency", 16'(cycles), 16'd8);
    checkOutput("b2b second busy", {15'd0, busyOk}, 16'd1);
    checkOutput("b2b second product", product8, 16'h01FE);
    @(negedge clock);
    checkOutput("b2b second donePulse", {15'd0, done8}, 16'd0);

    // reset sampled on the second stepping edge abandons the operation
    @(negedge clock);
    driveInputs(1'b0, 1'b1, 1'b0, 8'h0D, 8'h0B);
    @(negedge clock);
    driveInputs(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checkOutput("midreset busy", {15'd0, busy4}, 16'd0);
    checkOutput("midreset done", {15'd0, done4}, 16'd0);
    checkOutput("midreset product", {8'h00, product4}, 16'h0000);
    doneSeen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done4 !== 1'b0 || busy4 !== 1'b0) doneSeen = 1'b1;
      @(negedge clock);
    end
    checkOutput("midreset quiet", {15'd0, doneSeen}, 16'd0);
    applyStimulus("after reset u4 DxB", 1'b0, 1'b0, 8'h0D, 8'h0B, 16'h008F);

    // randomised operations against the integer reference
    for (int w = 0; w < 2; w++) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 50; k++) begin
          ra = 8'($urandom);
          rb = 8'($urandom);
          applyStimulus("random", w[0], m[0], ra, rb, refProduct(w[0], m[0], ra, rb));
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
